// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared VGA 640x480@60 timing constants, framebuffer address
//               map widths and the per-pixel flag bundle that travels with a
//               read request. Used by both the scanout and the line-drawing
//               core so both ends agree on addr = y*640 + x.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int FB_ADDR_W    = 19;
    localparam int CNT_W        = 10;

    typedef logic [CNT_W-1:0]     cnt_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    // Per-pixel attributes that must stay aligned with the pixel's read data.
    // Syncs are carried in their active-low pin polarity.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic origin;
    } vid_flags_t;

    localparam vid_flags_t FLAGS_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, origin: 1'b0};

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/framebuffer_scanout_if.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout_if
// Description : Framebuffer read port. One read per cycle, no handshake;
//               data returns a fixed number of cycles after the strobe.
//   fb_rd_en   : read strobe (master -> RAM)
//   fb_rd_addr : row-major pixel address (master -> RAM)
//   fb_rd_data : pixel bit (RAM -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface framebuffer_scanout_if;
    import vga_timing_pkg::*;

    logic     fb_rd_en;
    fb_addr_t fb_rd_addr;
    logic     fb_rd_data;

    modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
    modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);

endinterface : framebuffer_scanout_if
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Horizontal/vertical raster counters and the per-pixel flags
//               derived from them.
//   clk, rst   : pixel clock, synchronous active-high reset
//   flags      : active / hsync / vsync / origin for the current counter state
//   frame_last : high on the final cycle of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  wire logic clk,
    input  wire logic rst,
    output vid_flags_t flags,
    output logic       frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t C_H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t C_V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t C_H_ACT      = cnt_t'(H_ACTIVE);
    localparam cnt_t C_V_ACT      = cnt_t'(V_ACTIVE);
    localparam cnt_t C_HS_START   = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t C_HS_END     = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t C_VS_START   = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t C_VS_END     = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_last;
    logic v_last;

    assign h_last     = (h_cnt == C_H_LAST);
    assign v_last     = (v_cnt == C_V_LAST);
    assign frame_last = h_last && v_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        flags        = FLAGS_IDLE;
        flags.active = (h_cnt < C_H_ACT) && (v_cnt < C_V_ACT);
        flags.hsync  = !((h_cnt >= C_HS_START) && (h_cnt < C_HS_END));
        flags.vsync  = !((v_cnt >= C_VS_START) && (v_cnt < C_VS_END));
        flags.origin = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule : vga_timing_gen
`default_nettype wire

// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout
// Description : Reads the 1-bit framebuffer in raster order and drives VGA
//               sync, data enable and pixel, all aligned to the same cycle.
//   clk, rst    : pixel clock, synchronous active-high reset
//   fb          : framebuffer read port (master side)
//   hsync/vsync : active-low syncs
//   de          : data enable (active pixel)
//   pixel_out   : pixel bit, forced 0 outside the active region
//   frame_start : one-cycle pulse with pixel (0,0) on the outputs
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    // Read latency of the RAM, legal range 1..4
    parameter int RD_LATENCY = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    framebuffer_scanout_if.master fb,
    output logic hsync,
    output logic vsync,
    output logic de,
    output logic pixel_out,
    output logic frame_start
);

    vid_flags_t flags;
    logic       frame_last;
    fb_addr_t   addr_cnt;

    // dly[0] is registered together with the read strobe; dly[RD_LATENCY]
    // is therefore valid in the same cycle as that read's fb_rd_data.
    vid_flags_t [RD_LATENCY:0] dly;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .flags      (flags),
        .frame_last (frame_last)
    );

    // Row-major address advanced by one per active pixel; blanking keeps it
    // still, so each line naturally continues at y*H_ACTIVE. It is cleared on
    // the final frame cycle rather than by wrapping, so it never exceeds
    // H_ACTIVE*V_ACTIVE.
    always_ff @(posedge clk) begin
        if (rst || frame_last) begin
            addr_cnt <= '0;
        end else if (flags.active) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb.fb_rd_en   <= 1'b0;
            fb.fb_rd_addr <= '0;
        end else begin
            fb.fb_rd_en   <= flags.active;
            fb.fb_rd_addr <= addr_cnt;
        end
    end

    // Flushing to idle on reset drops any reads still in flight: their
    // returning data meets de=0 and is masked off.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly <= {(RD_LATENCY+1){FLAGS_IDLE}};
        end else begin
            dly <= {dly[RD_LATENCY-1:0], flags};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pixel_out   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= dly[RD_LATENCY].hsync;
            vsync       <= dly[RD_LATENCY].vsync;
            de          <= dly[RD_LATENCY].active;
            pixel_out   <= fb.fb_rd_data & dly[RD_LATENCY].active;
            frame_start <= dly[RD_LATENCY].origin;
        end
    end

endmodule : framebuffer_scanout
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_scanout
// Description : Bench for framebuffer_scanout. One instance with the default
//               640x480 timing (RD_LATENCY=2) and three with a reduced raster
//               (20x40 active, RD_LATENCY=1,2,4) so whole frames fit in a
//               short run. Expected values come from raster arithmetic on the
//               number of cycles since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;
    import vga_timing_pkg::*;

    localparam int N = 4;
    localparam int LAT [N] = '{2, 1, 2, 4};
    localparam int HA  [N] = '{640, 20, 20, 20};
    localparam int HF  [N] = '{16, 3, 3, 3};
    localparam int HS  [N] = '{96, 4, 4, 4};
    localparam int HB  [N] = '{48, 5, 5, 5};
    localparam int VA  [N] = '{480, 40, 40, 40};
    localparam int VF  [N] = '{10, 2, 2, 2};
    localparam int VS  [N] = '{2, 2, 2, 2};
    localparam int VB  [N] = '{33, 3, 3, 3};

    typedef struct packed {
        bit en;
        int addr;
        bit de;
        bit hs;
        bit vs;
        bit px;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        de_o [N];
    logic        hs_o [N];
    logic        vs_o [N];
    logic        px_o [N];
    logic        fs_o [N];
    logic        en_o [N];
    logic [18:0] addr_o [N];
    logic [3:0]  pipe [N];

    framebuffer_scanout_if fbif0 ();
    framebuffer_scanout_if fbif1 ();
    framebuffer_scanout_if fbif2 ();
    framebuffer_scanout_if fbif3 ();

    framebuffer_scanout #(.RD_LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .fb(fbif0),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]), .pixel_out(px_o[0]), .frame_start(fs_o[0]));
    framebuffer_scanout #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .fb(fbif1),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]), .pixel_out(px_o[1]), .frame_start(fs_o[1]));
    framebuffer_scanout #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .fb(fbif2),
        .hsync(hs_o[2]), .vsync(vs_o[2]), .de(de_o[2]), .pixel_out(px_o[2]), .frame_start(fs_o[2]));
    framebuffer_scanout #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LATENCY(4)) dut3 (
        .clk(clk), .rst(rst), .fb(fbif3),
        .hsync(hs_o[3]), .vsync(vs_o[3]), .de(de_o[3]), .pixel_out(px_o[3]), .frame_start(fs_o[3]));

    assign en_o[0] = fbif0.fb_rd_en;  assign addr_o[0] = fbif0.fb_rd_addr;
    assign en_o[1] = fbif1.fb_rd_en;  assign addr_o[1] = fbif1.fb_rd_addr;
    assign en_o[2] = fbif2.fb_rd_en;  assign addr_o[2] = fbif2.fb_rd_addr;
    assign en_o[3] = fbif3.fb_rd_en;  assign addr_o[3] = fbif3.fb_rd_addr;

    // RAM model: contents = addr[0]^addr[9]; a cycle without a read returns
    // random junk so unmasked pixel output would be visible.
    function automatic logic ram_bit(input logic [18:0] a);
        return a[0] ^ a[9];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            pipe[i] <= {pipe[i][2:0], (en_o[i] === 1'b1) ? ram_bit(addr_o[i]) : 1'($urandom)};
        end
    end

    assign fbif0.fb_rd_data = pipe[0][LAT[0]-1];
    assign fbif1.fb_rd_data = pipe[1][LAT[1]-1];
    assign fbif2.fb_rd_data = pipe[2][LAT[2]-1];
    assign fbif3.fb_rd_data = pipe[3][LAT[3]-1];

    int total = 0;
    int bad   = 0;
    int n     = 0;   // cycles since the first cycle with rst=0
    int cyc   = 0;
    logic rst_prev;

    // Expected observables in window n for instance i. Counter state in
    // window n is raster position n; its read shows at n+1 and its outputs
    // at n+1+LAT+1.
    function automatic exp_t model(input int i, input int nn);
        exp_t e;
        int k, h, v, a, ht, vt;
        ht = HA[i] + HF[i] + HS[i] + HB[i];
        vt = VA[i] + VF[i] + VS[i] + VB[i];
        e = '{en: 1'b0, addr: 0, de: 1'b0, hs: 1'b1, vs: 1'b1, px: 1'b0, fs: 1'b0};
        k = nn - 1;
        if (k >= 0) begin
            h = k % ht;
            v = (k / ht) % vt;
            e.en   = (h < HA[i]) && (v < VA[i]);
            e.addr = v * HA[i] + h;
        end
        k = nn - LAT[i] - 2;
        if (k >= 0) begin
            h = k % ht;
            v = (k / ht) % vt;
            a = v * HA[i] + h;
            e.de = (h < HA[i]) && (v < VA[i]);
            e.hs = !((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]));
            e.vs = !((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]));
            e.fs = (h == 0) && (v == 0);
            e.px = e.de && ((((a >> 0) & 1) ^ ((a >> 9) & 1)) != 0);
        end
        return e;
    endfunction

    task automatic tick();
        rst_prev = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_prev) n = 0;
        else n++;
    endtask

    task automatic test_reset();
        // initial hold
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                total++;
                if (de_o[i] !== 1'b0 || hs_o[i] !== 1'b1 || vs_o[i] !== 1'b1 || px_o[i] !== 1'b0 || fs_o[i] !== 1'b0 || en_o[i] !== 1'b0 || addr_o[i] !== 19'd0) begin
                    bad++;
                    $display("FAIL reset_hold dut%0d: got de=%b hs=%b vs=%b px=%b fs=%b en=%b addr=%0d, expected 0 1 1 0 0 0 0", i, de_o[i], hs_o[i], vs_o[i], px_o[i], fs_o[i], en_o[i], addr_o[i]);
                end
            end
        end
        rst = 1'b0;
        // run until the default raster sits at h=300 of line 0, then reset
        while (n < 300) begin
            tick();
            total++;
            if (en_o[0] !== model(0, n).en || (model(0, n).en && addr_o[0] !== 19'(model(0, n).addr))) begin
                bad++;
                $display("FAIL pre_reset_read n=%0d: got en=%b addr=%0d, expected en=%b addr=%0d", n, en_o[0], addr_o[0], model(0, n).en, model(0, n).addr);
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                total++;
                if (de_o[i] !== 1'b0 || hs_o[i] !== 1'b1 || vs_o[i] !== 1'b1 || px_o[i] !== 1'b0 || fs_o[i] !== 1'b0 || en_o[i] !== 1'b0 || addr_o[i] !== 19'd0) begin
                    bad++;
                    $display("FAIL reset_midline dut%0d: got de=%b hs=%b vs=%b px=%b fs=%b en=%b addr=%0d, expected 0 1 1 0 0 0 0", i, de_o[i], hs_o[i], vs_o[i], px_o[i], fs_o[i], en_o[i], addr_o[i]);
                end
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (en_o[0] !== 1'b1 || addr_o[0] !== 19'd0) begin
            bad++;
            $display("FAIL first_read: got en=%b addr=%0d, expected en=1 addr=0", en_o[0], addr_o[0]);
        end
    endtask

    task automatic test_line_addressing();
        while (n < 1610) begin
            tick();
            total++;
            if (en_o[0] !== model(0, n).en || (model(0, n).en && addr_o[0] !== 19'(model(0, n).addr))) begin
                bad++;
                $display("FAIL line_addr n=%0d: got en=%b addr=%0d, expected en=%b addr=%0d", n, en_o[0], addr_o[0], model(0, n).en, model(0, n).addr);
            end
            if (n == 801) begin
                total++;
                if (en_o[0] !== 1'b1 || addr_o[0] !== 19'd640) begin
                    bad++;
                    $display("FAIL line1_start: got en=%b addr=%0d, expected en=1 addr=640", en_o[0], addr_o[0]);
                end
            end
        end
    endtask

    task automatic test_hsync();
        int t_def, t_hf, t_hr, t_der, t_def2;
        logic de_p, hs_p;
        t_def = -1; t_hf = -1; t_hr = -1; t_der = -1; t_def2 = -1;
        de_p = de_o[0];
        hs_p = hs_o[0];
        for (int c = 0; c < 3000 && t_def2 < 0; c++) begin
            tick();
            if (de_p && !de_o[0]) begin
                if (t_def < 0) t_def = cyc;
                else if (t_der >= 0) t_def2 = cyc;
            end
            if (t_def >= 0 && t_hf < 0 && hs_p && !hs_o[0]) t_hf = cyc;
            if (t_hf >= 0 && t_hr < 0 && !hs_p && hs_o[0]) t_hr = cyc;
            if (t_hr >= 0 && t_der < 0 && !de_p && de_o[0]) t_der = cyc;
            de_p = de_o[0];
            hs_p = hs_o[0];
        end
        total++;
        if (t_def2 < 0) begin
            bad++;
            $display("FAIL hsync_timeout: edges seen def=%0d hf=%0d hr=%0d der=%0d def2=%0d, expected all", t_def, t_hf, t_hr, t_der, t_def2);
        end else begin
            total++;
            if (t_hf - t_def != 16) begin bad++; $display("FAIL front_porch: got %0d, expected 16", t_hf - t_def); end
            total++;
            if (t_hr - t_hf != 96) begin bad++; $display("FAIL hsync_width: got %0d, expected 96", t_hr - t_hf); end
            total++;
            if (t_der - t_hr != 48) begin bad++; $display("FAIL back_porch: got %0d, expected 48", t_der - t_hr); end
            total++;
            if (t_def2 - t_def != 800) begin bad++; $display("FAIL line_period: got %0d, expected 800", t_def2 - t_def); end
        end
    endtask

    task automatic test_data_alignment();
        exp_t e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2 * 1504 + 50; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                e = model(i, n);
                total++;
                if (de_o[i] !== e.de || hs_o[i] !== e.hs || vs_o[i] !== e.vs || px_o[i] !== e.px || fs_o[i] !== e.fs) begin
                    bad++;
                    $display("FAIL align dut%0d n=%0d: got de=%b hs=%b vs=%b px=%b fs=%b, expected de=%b hs=%b vs=%b px=%b fs=%b", i, n, de_o[i], hs_o[i], vs_o[i], px_o[i], fs_o[i], e.de, e.hs, e.vs, e.px, e.fs);
                end
                total++;
                if (en_o[i] !== e.en || (e.en && addr_o[i] !== 19'(e.addr))) begin
                    bad++;
                    $display("FAIL read_port dut%0d n=%0d: got en=%b addr=%0d, expected en=%b addr=%0d", i, n, en_o[i], addr_o[i], e.en, e.addr);
                end
            end
        end
    endtask

    task automatic test_frame();
        int t_fs1, t_fs2, t_vf, t_vr, t_der, last_addr;
        bit got_wrap;
        logic de_p, vs_p;
        t_fs1 = -1; t_fs2 = -1; t_vf = -1; t_vr = -1; t_der = -1; last_addr = -1;
        got_wrap = 1'b0;
        de_p = de_o[2];
        vs_p = vs_o[2];
        for (int c = 0; c < 3300 && !(t_fs2 >= 0 && t_vr >= 0 && got_wrap); c++) begin
            tick();
            if (fs_o[2]) begin
                total++;
                if (de_o[2] !== 1'b1) begin bad++; $display("FAIL frame_start_de: got de=%b, expected 1", de_o[2]); end
                if (t_fs1 < 0) t_fs1 = cyc;
                else if (t_fs2 < 0) t_fs2 = cyc;
            end
            if (de_o[2] && !de_p) t_der = cyc;
            if (!vs_o[2] && vs_p && t_vf < 0 && t_der >= 0) begin
                t_vf = cyc;
                total++;
                if (t_vf - t_der != 3 * 32) begin bad++; $display("FAIL vsync_start: got %0d, expected %0d", t_vf - t_der, 3 * 32); end
            end
            if (vs_o[2] && !vs_p && t_vf >= 0 && t_vr < 0) t_vr = cyc;
            if (en_o[2]) begin
                if (last_addr >= 0 && int'(addr_o[2]) < last_addr && !got_wrap) begin
                    got_wrap = 1'b1;
                    total++;
                    if (last_addr != 799) begin bad++; $display("FAIL last_addr: got %0d, expected 799", last_addr); end
                    total++;
                    if (addr_o[2] !== 19'd0) begin bad++; $display("FAIL wrap_addr: got %0d, expected 0", addr_o[2]); end
                end
                last_addr = int'(addr_o[2]);
            end
            de_p = de_o[2];
            vs_p = vs_o[2];
        end
        total++;
        if (t_fs2 < 0 || t_vr < 0 || !got_wrap) begin
            bad++;
            $display("FAIL frame_timeout: got fs1=%0d fs2=%0d vf=%0d vr=%0d wrap=%0d, expected all seen", t_fs1, t_fs2, t_vf, t_vr, got_wrap);
        end else begin
            total++;
            if (t_fs2 - t_fs1 != 1504) begin bad++; $display("FAIL frame_period: got %0d, expected 1504", t_fs2 - t_fs1); end
            total++;
            if (t_vr - t_vf != 64) begin bad++; $display("FAIL vsync_width: got %0d, expected 64", t_vr - t_vf); end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int target, hold;
        int first_de [N];
        for (int rep = 0; rep < 2; rep++) begin
            target = $urandom_range(30, 5) * 32 + $urandom_range(19, 0);
            hold   = $urandom_range(3, 1);
            for (int c = 0; c < 2000 && (n % 1504) != target; c++) begin
                tick();
            end
            total++;
            if ((n % 1504) != target) begin
                bad++;
                $display("FAIL reset_target_timeout: got pos=%0d, expected %0d", n % 1504, target);
            end
            rst = 1'b1;
            for (int c = 0; c < hold; c++) begin
                tick();
                for (int i = 1; i < N; i++) begin
                    total++;
                    if (de_o[i] !== 1'b0 || px_o[i] !== 1'b0 || en_o[i] !== 1'b0 || hs_o[i] !== 1'b1 || vs_o[i] !== 1'b1) begin
                        bad++;
                        $display("FAIL midframe_hold dut%0d: got de=%b px=%b en=%b hs=%b vs=%b, expected 0 0 0 1 1", i, de_o[i], px_o[i], en_o[i], hs_o[i], vs_o[i]);
                    end
                end
            end
            rst = 1'b0;
            for (int i = 0; i < N; i++) first_de[i] = -1;
            for (int c = 0; c < 200; c++) begin
                tick();
                for (int i = 1; i < N; i++) begin
                    e = model(i, n);
                    total++;
                    if (de_o[i] !== e.de || px_o[i] !== e.px || en_o[i] !== e.en || (e.en && addr_o[i] !== 19'(e.addr))) begin
                        bad++;
                        $display("FAIL after_reset dut%0d n=%0d: got de=%b px=%b en=%b addr=%0d, expected de=%b px=%b en=%b addr=%0d", i, n, de_o[i], px_o[i], en_o[i], addr_o[i], e.de, e.px, e.en, e.addr);
                    end
                    if (de_o[i] === 1'b1 && first_de[i] < 0) first_de[i] = n;
                end
            end
            for (int i = 1; i < N; i++) begin
                total++;
                if (first_de[i] != LAT[i] + 2) begin
                    bad++;
                    $display("FAIL first_de dut%0d: got n=%0d, expected n=%0d", i, first_de[i], LAT[i] + 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_addressing();
        test_hsync();
        test_data_alignment();
        test_frame();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_framebuffer_scanout
`default_nettype wire
